bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, width of each requester data word and of d_out.
REQ-002 SHALL have parameter MAX_TENURE, default 16, maximum grant length in cycles when the timeout feature is compiled in.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  8  request per requester; held high for the whole transfer.
REQ-006 SHALL have port d_in  input  8*DW  flattened requester data; requester i on bits [i*DW +: DW].
REQ-007 SHALL have port grant  output  8  registered one-hot grant; all zero when idle.
REQ-008 SHALL have port sel  output  3  registered index of the current or last owner; drives the shared 8-to-1 mux select.
REQ-009 SHALL have port d_out  output  DW  registered data word from the current owner.
REQ-010 SHALL have port d_valid  output  1  high for each cycle d_out carries owner data.
REQ-011 SHALL have port busy  output  1  high while state is BUSY.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE with req != 0, SHALL pick the first set req bit searching upward from ptr+1 mod 8, wrapping 7->0.
REQ-014 On a pick, SHALL set grant, sel and ptr to the winner at the next edge and enter BUSY (1-cycle req-to-grant latency).
REQ-015 In IDLE with req == 0, SHALL stay in IDLE with grant = 0; sel and d_out SHALL hold their values.
REQ-016 In BUSY, SHALL hold grant and sel constant while req[sel] = 1.
REQ-017 In BUSY, when req[sel] = 0, SHALL clear grant and return to IDLE at the next edge.
REQ-018 After each release, SHALL spend exactly one IDLE cycle before any new grant.
REQ-019 Requests from other requesters arriving during BUSY SHALL be ignored until IDLE; no preemption except as defined in REQ-028.
REQ-020 Each cycle in BUSY, SHALL register d_out <= d_in[sel*DW +: DW] and d_valid <= 1.
REQ-021 In all other cycles, d_valid SHALL be 0, so d_valid lags grant by one cycle.
REQ-022 busy SHALL equal (state == BUSY).
REQ-023 If req[sel] drops in the same cycle that other req bits rise, SHALL release first; the new requesters are arbitrated in the following IDLE cycle.

Reset
REQ-024 While reset = 1 at an edge, SHALL set state = IDLE, grant = 0, sel = 0, d_out = 0, d_valid = 0, ptr = 7 and tenure = 0.
REQ-025 Reset asserted during BUSY SHALL drop grant at that edge, with no residual d_valid.
REQ-026 After reset, requester 0 SHALL have highest priority for the first arbitration.

Configuration
REQ-027 SHALL support macro ARB_TIMEOUT_EN.
REQ-028 With ARB_TIMEOUT_EN defined:
- a tenure counter ($clog2(MAX_TENURE) bits) SHALL clear on entry to BUSY and increment each BUSY cycle;
- after MAX_TENURE BUSY cycles with req[sel] still high, SHALL force release to IDLE;
- ptr keeps the evicted index, so the evicted requester is lowest priority at the next arbitration.
REQ-029 Without ARB_TIMEOUT_EN, SHALL contain no tenure counter, and grant SHALL last until req[sel] drops.

Structure
REQ-030 SHALL place the state enum (IDLE/BUSY), the requester count constant (8) and the index width constant (3) in shared package arb_pkg.
REQ-031 SHALL implement the rotating first-one search as combinational sub-module rr_pick (inputs req[7:0], ptr[2:0]; outputs idx[2:0], found).
REQ-032 The data selection SHALL be an indexed part-select inside bus_rr_arbiter, with no separate mux instance.

Verification
REQ-033 Reset, then req = 8'b1000_0001 -> grant = 8'h01 and sel = 0 one cycle after req; d_valid = 1 with d_out = d_in word 0 one cycle later.
REQ-034 All 8 req high and each owner drops req 3 cycles after its grant -> grant order 0,1,2,...,7,0, with exactly one idle cycle between owners.
REQ-035 Owner 5 in BUSY, req[2] rises -> grant stays 8'h20 until req[5] drops, then 8'h04 two cycles later.
REQ-036 Reset pulse while owner 3 is BUSY -> grant = 0, sel = 0 and d_valid = 0 next cycle; the next arbitration with req = 8'h18 grants 3.
REQ-037 ARB_TIMEOUT_EN defined, MAX_TENURE = 16, req[4] held high alone -> grant revoked after 16 BUSY cycles and regranted after one idle cycle; with req[6] also high, 6 is granted next.
REQ-038 ARB_TIMEOUT_EN undefined, req[1] held high for 100 cycles -> grant = 8'h02 continuously and d_valid high for 100 consecutive cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_t : two-state arbiter FSM encoding (IDLE / BUSY)
//   NUM_REQ     : number of requesters (8)
//   IDX_W       : width of a requester index (3)
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one search for the round-robin arbiter.
// Ports:
//   req   in  [NUM_REQ-1:0] request vector
//   ptr   in  [IDX_W-1:0]   index of the last owner; search starts at ptr+1
//   idx   out [IDX_W-1:0]   index of the winning requester (0 when none)
//   found out               at least one request is set
// Purely combinational.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from the farthest (ptr+8 == ptr) down to the nearest
    // (ptr+1); later hits overwrite earlier ones, so the nearest set bit
    // above ptr wins and ptr itself is considered last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'(int'(ptr) + i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Eight-way round-robin bus arbiter with registered grant and data path.
// Ports:
//   clk      in                 rising-edge clock
//   reset    in                 synchronous, active-high reset
//   req      in  [7:0]          per-requester request, held for the transfer
//   d_in     in  [8*DW-1:0]     flattened requester data, word i at [i*DW +: DW]
//   grant    out [7:0]          registered one-hot grant, zero when idle
//   sel      out [2:0]          index of the current or last owner
//   d_out    out [DW-1:0]       registered data word of the owner
//   d_valid  out                d_out carries owner data this cycle
//   busy     out                arbiter is in BUSY
// Optional feature: define ARB_TIMEOUT_EN to add a tenure counter that
// forces release after MAX_TENURE BUSY cycles.
module bus_rr_arbiter
    import arb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MAX_TENURE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] d_in,
    output logic [NUM_REQ-1:0]    grant,
    output logic [IDX_W-1:0]      sel,
    output logic [DW-1:0]         d_out,
    output logic                  d_valid,
    output logic                  busy
);

    arb_state_t         state, state_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   sel_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               d_valid_d;
    logic               load_data;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               expired;
    logic               release_now;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;

    logic [TW-1:0] tenure;

    // Zero throughout IDLE, so it starts from zero on entry to BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            tenure <= '0;
        end else if (state == BUSY) begin
            tenure <= tenure + 1'b1;
        end else begin
            tenure <= '0;
        end
    end

    // Last permitted BUSY cycle: tenure counts 0..MAX_TENURE-1.
    assign expired = (tenure == TW'(MAX_TENURE - 1));
`else
    assign expired = 1'b0;
`endif

    assign release_now = ~req[sel] | expired;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_found)  state_d = BUSY;
            BUSY:    if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        grant_d   = grant;
        sel_d     = sel;
        ptr_d     = ptr;
        d_valid_d = 1'b0;
        load_data = 1'b0;
        case (state)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    ptr_d             = pick_idx;
                end
            end
            BUSY: begin
                d_valid_d = 1'b1;
                load_data = 1'b1;
                if (release_now) begin
                    grant_d = '0;
                end
            end
            default: grant_d = '0;
        endcase
    end

    // Output and data registers. ptr resets to 7 so requester 0 is the
    // first candidate after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant   <= '0;
            sel     <= '0;
            ptr     <= IDX_W'(NUM_REQ - 1);
            d_valid <= 1'b0;
            d_out   <= '0;
        end else begin
            grant   <= grant_d;
            sel     <= sel_d;
            ptr     <= ptr_d;
            d_valid <= d_valid_d;
            if (load_data) begin
                d_out <= d_in[sel*DW +: DW];
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed stimulus, expected grant
// sequence in a queue, separate monitor comparing grants and data words.
module tb_bus_rr_arbiter;

    localparam int DW = 32;
    localparam int NR = 8;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] d_in;
    logic [NR-1:0]   grant;
    logic [2:0]      sel;
    logic [DW-1:0]   d_out;
    logic            d_valid;
    logic            busy;

    logic [DW-1:0]   words[NR];
    logic [NR-1:0]   exp_q[$];

    int              total;
    int              bad;

    logic [NR-1:0]   prev_grant;
    logic [NR-1:0]   e;
    int              exp_owner;
    logic [DW-1:0]   last_word;

    bus_rr_arbiter #(.DW(DW), .MAX_TENURE(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .d_in    (d_in),
        .grant   (grant),
        .sel     (sel),
        .d_out   (d_out),
        .d_valid (d_valid),
        .busy    (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        d_in = '0;
        for (int i = 0; i < NR; i++) d_in[i*DW +: DW] = words[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: grant sequence and owner data
    initial begin
        prev_grant = '0;
        exp_owner  = 0;
        last_word  = '0;
    end

    always @(negedge clk) begin
        if (d_valid) check("d_out_word", d_out, last_word);
        if (grant != '0 && grant != prev_grant) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", grant, '0);
            end else begin
                e = exp_q.pop_front();
                check("grant_seq", grant, e);
                check("sel_on_grant", sel, idx_of(e));
                exp_owner = idx_of(e);
            end
        end
        prev_grant = grant;
        last_word  = words[exp_owner];
    end

    initial begin
        int held;
        logic [2:0] own;
        total = 0;
        bad   = 0;
        for (int i = 0; i < NR; i++) words[i] = 32'hA5A5_0000 | (i * 32'h0000_1111);
        req   = '0;
        reset = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_grant", grant, 8'h00);
        check("rst_sel", sel, 3'd0);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_d_out", d_out, '0);
        check("rst_busy", busy, 1'b0);

        // requester 0 wins over 7 first after reset
        reset = 1'b0;
        req = 8'h81;
        exp_q.push_back(8'h01);
        tick();
        check("first_grant", grant, 8'h01);
        check("first_sel", sel, 3'd0);
        check("first_dv_lag", d_valid, 1'b0);
        tick();
        check("first_dv", d_valid, 1'b1);
        check("first_dout", d_out, words[0]);
        req = 8'h80;
        exp_q.push_back(8'h80);
        tick();
        check("release0_grant", grant, 8'h00);
        check("release0_dv", d_valid, 1'b1);
        tick();
        check("grant7", grant, 8'h80);
        check("grant7_dv", d_valid, 1'b0);
        req = 8'h00;
        tick();
        tick();
        check("idle_hold_sel", sel, 3'd7);
        check("idle_dv", d_valid, 1'b0);

        // full rotation, one idle cycle between owners
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            own = 3'(k % 8);
            exp_q.push_back(8'h01 << own);
            tick();
            check("rr_grant", grant, 8'h01 << own);
            tick();
            check("rr_hold", grant, 8'h01 << own);
            tick();
            check("rr_hold", grant, 8'h01 << own);
            req[own] = 1'b0;
            tick();
            check("rr_release", grant, 8'h00);
            if (k < 8) req[own] = 1'b1;
        end
        req = 8'h00;
        tick();
        check("rr_idle", busy, 1'b0);

        // no preemption; release first, then new requester
        req = 8'h20;
        exp_q.push_back(8'h20);
        tick();
        check("own5_grant", grant, 8'h20);
        req = 8'h24;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("own5_hold", grant, 8'h20);
        end
        req = 8'h04;
        exp_q.push_back(8'h04);
        tick();
        check("own5_release", grant, 8'h00);
        tick();
        check("own2_grant", grant, 8'h04);
        req = 8'h00;
        tick();
        tick();

        // reset while busy
        req = 8'h08;
        exp_q.push_back(8'h08);
        tick();
        check("own3_grant", grant, 8'h08);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_grant", grant, 8'h00);
        check("midrst_sel", sel, 3'd0);
        check("midrst_dv", d_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        req = 8'h18;
        exp_q.push_back(8'h08);
        tick();
        check("postrst_grant", grant, 8'h08);
        check("postrst_sel", sel, 3'd3);
        req = 8'h00;
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        // forced release after 16 BUSY cycles
        req = 8'h10;
        exp_q.push_back(8'h10);
        tick();
        held = (grant == 8'h10) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant != 8'h10) break;
            held++;
        end
        check("tenure_len", held, 16);
        check("tenure_idle", grant, 8'h00);
        exp_q.push_back(8'h10);
        tick();
        check("tenure_regrant", grant, 8'h10);
        req = 8'h50;
        exp_q.push_back(8'h40);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant != 8'h10) break;
        end
        check("tenure_idle2", grant, 8'h00);
        tick();
        check("tenure_next6", grant, 8'h40);
        req = 8'h00;
        tick();
        tick();
`else
        // long tenure without timeout
        req = 8'h02;
        exp_q.push_back(8'h02);
        tick();
        check("long_grant", grant, 8'h02);
        held = 0;
        for (int i = 0; i < 100; i++) begin
            words[1] = $urandom;
            tick();
            if (grant == 8'h02 && d_valid) held++;
        end
        check("long_cycles", held, 100);
        req = 8'h00;
        tick();
        check("long_release", grant, 8'h00);
        tick();
        check("long_dv_off", d_valid, 1'b0);
`endif

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
